// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock, LSB first, using a single
// full-subtractor cell and a borrow register. Ready/valid on both sides.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             a_msb, b_msb;

  logic             accept_c;
  logic             last_c;
  logic             d_bit_c;
  logic             borrow_nxt_c;
  logic [WIDTH-1:0] res_nxt_c;

  // Full-subtractor cell and next-state decode
  always_comb begin
    next_state   = state;
    accept_c     = 1'b0;
    last_c       = 1'b0;
    d_bit_c      = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_nxt_c = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    res_nxt_c    = {d_bit_c, res_sh};
    case (state)
      IDLE: begin
        if (start_valid) begin
          accept_c   = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_c     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Operand shifters, borrow chain and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else if (accept_c) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      cnt    <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt_c[WIDTH-1:1];
      borrow <= borrow_nxt_c;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result is captured on the final RUN edge and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_ready <= 1'b0;
      res_valid   <= 1'b0;
      diff        <= '0;
      bout        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      start_ready <= (next_state == IDLE);
      res_valid   <= (next_state == DONE);
      if (last_c) begin
        diff <= res_nxt_c;
        bout <= borrow_nxt_c;
        ovf  <= (a_msb ^ b_msb) & (res_nxt_c[WIDTH-1] ^ a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors, backpressure, mid-run reset
// and randomized regression at WIDTH=8 and WIDTH=2 against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       sv8 = 1'b0, rr8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       sr8, rv8, bo8, ov8;
  logic [7:0] d8;

  logic       sv2 = 1'b0, rr2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       sr2, rv2, bo2, ov2;
  logic [1:0] d2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .bin(bin8), .res_valid(rv8), .res_ready(rr8),
    .diff(d8), .bout(bo8), .ovf(ov8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2),
    .a(a2), .b(b2), .bin(bin2), .res_valid(rv2), .res_ready(rr2),
    .diff(d2), .bout(bo2), .ovf(ov2)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void ref_sub(input int w, input int a, input int b, input int bi,
                                  output int d, output bit bo, output bit ov);
    int m, raw, sa, sb, sd;
    m   = 1 << w;
    raw = a - b - bi;
    d   = ((raw % m) + m) % m;
    bo  = (a < b + bi);
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    sd  = sa - sb - bi;
    ov  = (sd < -(m / 2)) || (sd > m / 2 - 1);
  endfunction

  // start_ready and res_valid must never be high together
  always @(negedge clk) begin
    if (rst_n) begin
      total += 2;
      if (sr8 && rv8) begin
        bad++;
        $display("FAIL excl8: start_ready=%0b res_valid=%0b both high", sr8, rv8);
      end
      if (sr2 && rv2) begin
        bad++;
        $display("FAIL excl2: start_ready=%0b res_valid=%0b both high", sr2, rv2);
      end
    end
  end

  task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic ebo, input logic eov,
                      input int stall, input bit poke);
    int n;
    n = 0;
    while (!sr8 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (!sr8) begin bad++; $display("FAIL ready8: start_ready=%0b required 1", sr8); end
    a8 = a; b8 = b; bin8 = bi; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    n = 0;
    while (!rv8 && n < 20) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      sv8 = poke ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    sv8 = 1'b0;
    total++;
    if (n != 8) begin bad++; $display("FAIL latency8: got %0d cycles required 8", n); end
    total++;
    if (d8 !== ed || bo8 !== ebo || ov8 !== eov) begin
      bad++;
      $display("FAIL result8 a=%h b=%h bin=%0b: got d=%h bo=%0b ov=%0b required d=%h bo=%0b ov=%0b",
               a, b, bi, d8, bo8, ov8, ed, ebo, eov);
    end
    repeat (stall) begin
      @(posedge clk); #1;
      total++;
      if (rv8 !== 1'b1 || sr8 !== 1'b0 || d8 !== ed || bo8 !== ebo || ov8 !== eov) begin
        bad++;
        $display("FAIL hold8: rv=%0b sr=%0b d=%h bo=%0b ov=%0b required rv=1 sr=0 d=%h bo=%0b ov=%0b",
                 rv8, sr8, d8, bo8, ov8, ed, ebo, eov);
      end
    end
    rr8 = 1'b1;
    @(posedge clk); #1;
    rr8 = 1'b0;
    total++;
    if (rv8 !== 1'b0 || sr8 !== 1'b1) begin
      bad++;
      $display("FAIL release8: rv=%0b sr=%0b required rv=0 sr=1", rv8, sr8);
    end
  endtask

  task automatic txn2(input logic [1:0] a, input logic [1:0] b, input logic bi,
                      input logic [1:0] ed, input logic ebo, input logic eov, input int stall);
    int n;
    n = 0;
    while (!sr2 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (!sr2) begin bad++; $display("FAIL ready2: start_ready=%0b required 1", sr2); end
    a2 = a; b2 = b; bin2 = bi; sv2 = 1'b1;
    @(posedge clk); #1;
    sv2 = 1'b0;
    n = 0;
    while (!rv2 && n < 20) begin
      a2 = 2'($urandom); b2 = 2'($urandom); bin2 = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL latency2: got %0d cycles required 2", n); end
    total++;
    if (d2 !== ed || bo2 !== ebo || ov2 !== eov) begin
      bad++;
      $display("FAIL result2 a=%h b=%h bin=%0b: got d=%h bo=%0b ov=%0b required d=%h bo=%0b ov=%0b",
               a, b, bi, d2, bo2, ov2, ed, ebo, eov);
    end
    repeat (stall) begin
      @(posedge clk); #1;
      total++;
      if (rv2 !== 1'b1 || d2 !== ed || bo2 !== ebo || ov2 !== eov) begin
        bad++;
        $display("FAIL hold2: rv=%0b d=%h required rv=1 d=%h", rv2, d2, ed);
      end
    end
    rr2 = 1'b1;
    @(posedge clk); #1;
    rr2 = 1'b0;
    total++;
    if (rv2 !== 1'b0 || sr2 !== 1'b1) begin
      bad++;
      $display("FAIL release2: rv=%0b sr=%0b required rv=0 sr=1", rv2, sr2);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (sr8 !== 1'b0 || rv8 !== 1'b0 || d8 !== 8'h00 || bo8 !== 1'b0 || ov8 !== 1'b0) begin
      bad++;
      $display("FAIL reset: sr=%0b rv=%0b d=%h bo=%0b ov=%0b required all 0", sr8, rv8, d8, bo8, ov8);
    end
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (sr8 !== 1'b1 || rv8 !== 1'b0 || sr2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: sr8=%0b rv8=%0b sr2=%0b required 1 0 1", sr8, rv8, sr2);
    end
  endtask

  task automatic test_directed();
    txn8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 0, 1'b0);
    txn8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    txn8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 1'b0);
    txn8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    txn8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    txn8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    txn8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 5, 1'b1);
    txn8(8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0, 5, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (sr8 !== 1'b0 || rv8 !== 1'b0 || d8 !== 8'h00 || bo8 !== 1'b0 || ov8 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: sr=%0b rv=%0b d=%h bo=%0b ov=%0b required all 0", sr8, rv8, d8, bo8, ov8);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (sr8 !== 1'b1 || rv8 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_idle: sr=%0b rv=%0b required sr=1 rv=0", sr8, rv8);
    end
    txn8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random8();
    int ed;
    bit ebo, eov;
    logic [7:0] a, b;
    logic bi;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
      ref_sub(8, int'(a), int'(b), int'(bi), ed, ebo, eov);
      txn8(a, b, bi, 8'(ed), ebo, eov, int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  task automatic test_random2();
    int ed;
    bit ebo, eov;
    logic [1:0] a, b;
    logic bi;
    for (int i = 0; i < 1000; i++) begin
      a = 2'($urandom); b = 2'($urandom); bi = 1'($urandom);
      ref_sub(2, int'(a), int'(b), int'(bi), ed, ebo, eov);
      txn2(a, b, bi, 2'(ed), ebo, eov, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random8();
    test_random2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

endmodule
